// File: rtl/fp32_coproc_pkg.sv
// rtl/fp32_coproc_pkg.sv - shared types and constants for the fp32 co-processor blocks
package fp32_coproc_pkg;

  localparam int FP32_W = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RES = 2'd2,
    RESPOND  = 2'd3
  } arb_state_e;

  // Circular successor of a requester index.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mult_fp32_arbiter_if.sv
// rtl/mult_fp32_arbiter_if.sv - requester, response and multiplier signals of the shared-multiplier arbiter
interface mult_fp32_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
);
  import fp32_coproc_pkg::*;

  logic [NUM_REQ*FP32_W-1:0] req_input_a;
  logic [NUM_REQ*FP32_W-1:0] req_input_b;
  logic [NUM_REQ-1:0]        req_STB;
  logic [NUM_REQ-1:0]        req_BUSY;
  logic [FP32_W-1:0]         rsp_result;
  logic [NUM_REQ-1:0]        rsp_STB;
  logic [NUM_REQ-1:0]        rsp_BUSY;
  logic [FP32_W-1:0]         mult_a;
  logic [FP32_W-1:0]         mult_b;
  logic                      mult_input_STB;
  logic                      mult_BUSY;
  logic [FP32_W-1:0]         mult_result;
  logic                      mult_output_STB;
  logic                      mult_output_module_BUSY;
  logic [IDX_W-1:0]          grant_idx;

  // The arbiter is the slave; requesters, consumers and the multiplier form the master side.
  modport slave (
    input  req_input_a, req_input_b, req_STB, rsp_BUSY,
    input  mult_BUSY, mult_result, mult_output_STB,
    output req_BUSY, rsp_result, rsp_STB,
    output mult_a, mult_b, mult_input_STB, mult_output_module_BUSY, grant_idx
  );

  modport master (
    output req_input_a, req_input_b, req_STB, rsp_BUSY,
    output mult_BUSY, mult_result, mult_output_STB,
    input  req_BUSY, rsp_result, rsp_STB,
    input  mult_a, mult_b, mult_input_STB, mult_output_module_BUSY, grant_idx
  );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational rotating-priority pick of the first request at or after ptr
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  logic [2*N-1:0] dbl;
  int             off;
  int             sum;

  // Rotating the doubled vector by ptr puts request (ptr+k) mod N at bit k.
  always_comb begin
    dbl = {req, req} >> ptr;
    off = 0;
    any = |req;
    for (int k = N - 1; k >= 0; k--) begin
      if (dbl[k]) off = k;
    end
    sum = int'(ptr) + off;
    if (sum >= N) sum = sum - N;
    gnt_idx = IDX_W'(sum);
  end

endmodule

// File: rtl/mult_fp32_arbiter.sv
// rtl/mult_fp32_arbiter.sv - round-robin scheduler sharing one fp32 multiplier between NUM_REQ requesters
module mult_fp32_arbiter
  import fp32_coproc_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input logic                clk,
  input logic                rst,
  mult_fp32_arbiter_if.slave bus
);

  arb_state_e        state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  pick;
  logic              pick_any;
  logic [FP32_W-1:0] op_a [NUM_REQ];
  logic [FP32_W-1:0] op_b [NUM_REQ];

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      op_a[k] = bus.req_input_a[k*FP32_W +: FP32_W];
      op_b[k] = bus.req_input_b[k*FP32_W +: FP32_W];
    end
  end

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req     (bus.req_STB),
    .ptr     (rr_ptr),
    .gnt_idx (pick),
    .any     (pick_any)
  );

  // Requests are only looked at in IDLE, so a strobe still held during RESPOND is not a new request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                       <= IDLE;
      rr_ptr                      <= '0;
      bus.grant_idx               <= '0;
      bus.req_BUSY                <= '0;
      bus.rsp_STB                 <= '0;
      bus.rsp_result              <= '0;
      bus.mult_a                  <= '0;
      bus.mult_b                  <= '0;
      bus.mult_input_STB          <= 1'b0;
      bus.mult_output_module_BUSY <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            bus.mult_a          <= op_a[pick];
            bus.mult_b          <= op_b[pick];
            bus.grant_idx       <= pick;
            bus.req_BUSY[pick]  <= 1'b1;
            bus.mult_input_STB  <= 1'b1;
            rr_ptr              <= IDX_W'(wrap_inc(int'(pick), NUM_REQ));
            state               <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.mult_input_STB && bus.mult_BUSY) begin
            bus.mult_input_STB          <= 1'b0;
            bus.mult_output_module_BUSY <= 1'b0;
            state                       <= WAIT_RES;
          end
        end
        WAIT_RES: begin
          if (bus.mult_output_STB && !bus.mult_output_module_BUSY) begin
            bus.rsp_result              <= bus.mult_result;
            bus.mult_output_module_BUSY <= 1'b1;
            bus.rsp_STB[bus.grant_idx]  <= 1'b1;
            state                       <= RESPOND;
          end
        end
        RESPOND: begin
          // Multiplier is already released here; only the consumer can hold us.
          if (bus.rsp_STB[bus.grant_idx] && !bus.rsp_BUSY[bus.grant_idx]) begin
            bus.rsp_STB[bus.grant_idx]  <= 1'b0;
            bus.req_BUSY[bus.grant_idx] <= 1'b0;
            state                       <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_fp32_arbiter.sv
// tb/tb_mult_fp32_arbiter.sv - scoreboard bench for the shared-multiplier arbiter
module tb_mult_fp32_arbiter;
  import fp32_coproc_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mult_fp32_arbiter_if #(.NUM_REQ(N)) bus ();

  mult_fp32_arbiter #(.NUM_REQ(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          idx;
    logic [31:0] res;
  } exp_t;
  exp_t exp_q[$];

  // Hand-computed fp32 products the multiplier model knows about.
  logic [31:0] va [8] = '{32'h40000000, 32'h00000000, 32'h3F800000, 32'h40000000,
                          32'h40400000, 32'h40400000, 32'h3FC00000, 32'hC0000000};
  logic [31:0] vb [8] = '{32'h40400000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
                          32'h3F800000, 32'h40000000, 32'h40000000, 32'h40400000};
  logic [31:0] vp [8] = '{32'h40C00000, 32'h00000000, 32'h3F800000, 32'h40000000,
                          32'h40400000, 32'h40C00000, 32'h40400000, 32'hC0C00000};

  function automatic logic [31:0] lookup(input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < 8; i++) if (va[i] == a && vb[i] == b) return vp[i];
    return 32'hDEADBEEF;
  endfunction

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  logic [31:0] op_a [N];
  logic [31:0] op_b [N];
  int          req_cnt [N];
  int          srv_cnt [N];

  for (genvar g = 0; g < N; g++) begin : g_ops
    assign bus.req_input_a[g*32 +: 32] = op_a[g];
    assign bus.req_input_b[g*32 +: 32] = op_b[g];
  end

  // Requesters: raise when a request is pending, drop once req_BUSY is seen.
  initial begin
    bus.req_STB = '0;
    for (int i = 0; i < N; i++) srv_cnt[i] = 0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (bus.req_STB[i] && bus.req_BUSY[i]) bus.req_STB[i] = 1'b0;
        else if (!bus.req_STB[i] && !bus.req_BUSY[i] && req_cnt[i] > srv_cnt[i]) begin
          bus.req_STB[i] = 1'b1;
          srv_cnt[i]++;
        end
      end
    end
  end

  // Multiplier model: ack after ack_delay cycles, product two cycles later.
  int          ack_delay = 0;
  int          issues = 0;
  int          m_st = 0;
  int          dly = 0;
  int          lat = 0;
  bit          prev_pend = 0;
  logic [31:0] prev_a, prev_b, cap_a, cap_b;

  initial begin
    bus.mult_BUSY       = 1'b0;
    bus.mult_output_STB = 1'b0;
    bus.mult_result     = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bus.mult_BUSY       = 1'b0;
        bus.mult_output_STB = 1'b0;
        m_st = 0; dly = 0; prev_pend = 0;
      end else begin
        if (m_st == 3) begin
          bus.mult_output_STB = 1'b0;
          bus.mult_BUSY       = 1'b0;
          m_st = 0;
        end else if (m_st == 1) begin
          if (lat == 0) begin
            bus.mult_result     = lookup(cap_a, cap_b);
            bus.mult_output_STB = 1'b1;
            m_st = 2;
          end else lat--;
        end else if (m_st == 0 && bus.mult_input_STB) begin
          if (prev_pend) begin
            check_eq("mult_a_stable", bus.mult_a, prev_a);
            check_eq("mult_b_stable", bus.mult_b, prev_b);
          end
          prev_pend = 1; prev_a = bus.mult_a; prev_b = bus.mult_b;
          if (dly >= ack_delay) begin
            bus.mult_BUSY = 1'b1;
            cap_a = bus.mult_a; cap_b = bus.mult_b;
            issues++;
            lat = 2; dly = 0; prev_pend = 0;
            m_st = 1;
          end else dly++;
        end
        if (m_st == 2 && !bus.mult_output_module_BUSY) m_st = 3;
      end
    end
  end

  // Monitor: a response is taken at the next edge when its strobe is up and the consumer is free.
  int   resp_count = 0;
  exp_t e;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.rsp_STB != '0 && (bus.rsp_STB & bus.rsp_BUSY) == '0) begin
        resp_count++;
        if (exp_q.size() == 0) begin
          check_eq("unexpected_rsp", 32'(bus.rsp_STB), 32'h0);
        end else begin
          e = exp_q.pop_front();
          check_eq("rsp_stb_onehot", 32'(bus.rsp_STB), 32'h1 << e.idx);
          check_eq("rsp_result", bus.rsp_result, e.res);
          check_eq("rsp_grant_idx", 32'(bus.grant_idx), e.idx);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic request(input int i, input logic [31:0] a, input logic [31:0] b);
    op_a[i] = a;
    op_b[i] = b;
    req_cnt[i]++;
  endtask

  task automatic expect_rsp(input int i, input logic [31:0] p);
    exp_t x;
    x.idx = i;
    x.res = p;
    exp_q.push_back(x);
  endtask

  task automatic drain(input string name);
    bit done;
    done = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      tick(1);
      done = (exp_q.size() == 0) && (bus.req_BUSY == '0) && (bus.req_STB == '0) &&
             (bus.rsp_STB == '0);
      for (int i = 0; i < N; i++) if (req_cnt[i] != srv_cnt[i]) done = 0;
    end
    check_eq(name, 32'(done), 32'h1);
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_req_busy"}, 32'(bus.req_BUSY), 32'h0);
    check_eq({tag, "_rsp_stb"}, 32'(bus.rsp_STB), 32'h0);
    check_eq({tag, "_mult_stb"}, 32'(bus.mult_input_STB), 32'h0);
    check_eq({tag, "_out_busy"}, 32'(bus.mult_output_module_BUSY), 32'h1);
    check_eq({tag, "_rsp_result"}, bus.rsp_result, 32'h0);
    check_eq({tag, "_mult_a"}, bus.mult_a, 32'h0);
    check_eq({tag, "_mult_b"}, bus.mult_b, 32'h0);
    check_eq({tag, "_grant_idx"}, 32'(bus.grant_idx), 32'h0);
    check_eq({tag, "_state"}, 32'(dut.state), 32'(IDLE));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  bit seen, dropped, got, ok_stb, ok_res, ok_busy, ok_istb, ok_obusy;
  int snap;

  initial begin
    rst = 1'b1;
    bus.rsp_BUSY = '0;
    for (int i = 0; i < N; i++) begin
      op_a[i] = '0; op_b[i] = '0; req_cnt[i] = 0;
    end
    tick(3);
    check_reset("reset");
    rst = 1'b0;

    // Single request: 2.0 x 3.0 from requester 1.
    request(1, 32'h40000000, 32'h40400000);
    expect_rsp(1, 32'h40C00000);
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick(1);
      seen = bus.req_BUSY[1];
    end
    check_eq("t1_busy_raised", 32'(seen), 32'h1);
    check_eq("t1_stb_at_capture", 32'(bus.mult_input_STB), 32'h1);
    check_eq("t1_grant_idx", 32'(bus.grant_idx), 32'h1);
    check_eq("t1_mult_a", bus.mult_a, 32'h40000000);
    check_eq("t1_mult_b", bus.mult_b, 32'h40400000);
    dropped = 0; got = 0;
    for (int c = 0; c < 50 && !got; c++) begin
      tick(1);
      if (bus.rsp_STB != '0) got = 1;
      else if (!bus.req_BUSY[1]) dropped = 1;
    end
    check_eq("t1_rsp_seen", 32'(got), 32'h1);
    check_eq("t1_busy_held", 32'(dropped), 32'h0);
    check_eq("t1_busy_at_rsp", 32'(bus.req_BUSY[1]), 32'h1);
    tick(1);
    check_eq("t1_busy_cleared", 32'(bus.req_BUSY), 32'h0);
    check_eq("t1_rsp_cleared", 32'(bus.rsp_STB), 32'h0);
    drain("t1_drain");

    // Simultaneous requests after reset: grants 0,1,2,3.
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    request(0, 32'h00000000, 32'h3F800000);
    request(1, 32'h3F800000, 32'h3F800000);
    request(2, 32'h40000000, 32'h3F800000);
    request(3, 32'h40400000, 32'h3F800000);
    expect_rsp(0, 32'h00000000);
    expect_rsp(1, 32'h3F800000);
    expect_rsp(2, 32'h40000000);
    expect_rsp(3, 32'h40400000);
    drain("t2_drain");

    // Round robin from pointer 2 with requests on 0 and 3.
    request(1, 32'h40400000, 32'h40000000);
    expect_rsp(1, 32'h40C00000);
    drain("t3a_drain");
    check_eq("t3_rr_ptr", 32'(dut.rr_ptr), 32'h2);
    request(0, 32'h3FC00000, 32'h40000000);
    request(3, 32'hC0000000, 32'h40400000);
    expect_rsp(3, 32'hC0C00000);
    expect_rsp(0, 32'h40400000);
    drain("t3b_drain");

    // Response backpressure on requester 2 with requester 0 waiting.
    bus.rsp_BUSY[2] = 1'b1;
    request(2, 32'hC0000000, 32'h40400000);
    expect_rsp(2, 32'hC0C00000);
    seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      tick(1);
      seen = bus.rsp_STB[2];
    end
    check_eq("t4_rsp_seen", 32'(seen), 32'h1);
    request(0, 32'h3F800000, 32'h3F800000);
    expect_rsp(0, 32'h3F800000);
    snap = issues;
    ok_stb = 1; ok_res = 1; ok_busy = 1; ok_istb = 1; ok_obusy = 1;
    for (int c = 0; c < 20; c++) begin
      tick(1);
      if (bus.rsp_STB != 4'b0100) ok_stb = 0;
      if (bus.rsp_result != 32'hC0C00000) ok_res = 0;
      if (bus.req_BUSY != 4'b0100) ok_busy = 0;
      if (bus.mult_input_STB) ok_istb = 0;
      if (!bus.mult_output_module_BUSY) ok_obusy = 0;
    end
    check_eq("t4_rsp_stb_stable", 32'(ok_stb), 32'h1);
    check_eq("t4_rsp_result_stable", 32'(ok_res), 32'h1);
    check_eq("t4_no_new_grant", 32'(ok_busy), 32'h1);
    check_eq("t4_mult_stb_low", 32'(ok_istb), 32'h1);
    check_eq("t4_out_busy_high", 32'(ok_obusy), 32'h1);
    check_eq("t4_no_issue", 32'(issues - snap), 32'h0);
    bus.rsp_BUSY[2] = 1'b0;
    drain("t4_drain");

    // Reset while waiting for the product.
    request(2, 32'h40000000, 32'h3F800000);
    expect_rsp(2, 32'h40000000);
    seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      tick(1);
      seen = bus.req_BUSY[2] && !bus.mult_output_module_BUSY;
    end
    check_eq("t5_wait_res", 32'(seen), 32'h1);
    rst = 1'b1;
    exp_q.delete();
    tick(1);
    check_reset("t5");
    rst = 1'b0;
    tick(1);
    request(2, 32'h40000000, 32'h40400000);
    expect_rsp(2, 32'h40C00000);
    drain("t5_drain");

    // Multiplier acknowledges 5 cycles late.
    ack_delay = 5;
    snap = issues;
    request(3, 32'h40400000, 32'h40000000);
    expect_rsp(3, 32'h40C00000);
    drain("t6_drain");
    check_eq("t6_one_issue", 32'(issues - snap), 32'h1);
    ack_delay = 0;

    tick(5);
    check_eq("total_responses", 32'(resp_count), 32'd12);
    check_eq("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
